// File: rtl/gate_direction_counter.sv
// ---------------------------------------------------------------------------
// gate_direction_counter
//
// Purpose:
//   Watches two debounced gate sensors (A and B). It tracks the order in which
//   they assert and release, so it can tell a forward passage (A first, then
//   B) from a reverse passage (B first, then A). It keeps a saturating
//   occupancy count, aborts sequences that stall mid-way, and shows a timed
//   status window after every completed passage.
//
// Parameters:
//   WIDTH        - count width in bits
//   MAX_COUNT    - saturation ceiling for the count (1 .. 2**WIDTH-1)
//   TIMEOUT      - idle cycles allowed in a mid-sequence state before abort
//   HOLD_CYCLES  - length of the status window after a passage
//
// Ports:
//   i_clk        - system clock, rising edge
//   i_rst        - synchronous active-high reset
//   i_sens_a     - sensor A, debounced and synchronous to i_clk
//   i_sens_b     - sensor B, debounced and synchronous to i_clk
//   i_clear      - synchronous count clear (the FSM is not affected)
//   o_count      - current occupancy
//   o_inc_pulse  - one cycle: the count was incremented
//   o_dec_pulse  - one cycle: the count was decremented
//   o_rej_pulse  - one cycle: a passage was rejected because of saturation
//   o_err_pulse  - one cycle: a sequence was aborted by timeout
//   o_showstat   - high while the status window (HOLD) is active
//   o_busy       - high while a passage is in progress or sensors must release
//   o_full       - count equals MAX_COUNT
//   o_empty      - count equals zero
// ---------------------------------------------------------------------------
module gate_direction_counter #(
  parameter int WIDTH       = 8,
  parameter int MAX_COUNT   = 255,
  parameter int TIMEOUT     = 1000,
  parameter int HOLD_CYCLES = 50
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sens_a,
  input  logic             i_sens_b,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count,
  output logic             o_inc_pulse,
  output logic             o_dec_pulse,
  output logic             o_rej_pulse,
  output logic             o_err_pulse,
  output logic             o_showstat,
  output logic             o_busy,
  output logic             o_full,
  output logic             o_empty
);

  // The timer serves both the mid-sequence timeout and the HOLD window, so
  // it is sized for the larger of the two limits.
  localparam int MAX_TIME = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
  localparam int TW       = $clog2(MAX_TIME + 1);

  localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]    HOLD_LAST    = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]    TIMER_MAX    = TW'(MAX_TIME);
  localparam logic [WIDTH-1:0] COUNT_MAX    = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] COUNT_ONE    = WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_F1,
    S_F2,
    S_F3,
    S_R1,
    S_R2,
    S_R3,
    S_HOLD,
    S_WAIT_REL
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [TW-1:0]    r_timer;
  logic [WIDTH-1:0] r_count;
  logic             r_incPulse;
  logic             r_decPulse;
  logic             r_rejPulse;
  logic             r_errPulse;

  logic [1:0]       w_ab;
  logic             w_midSeq;
  logic             w_incReq;
  logic             w_decReq;
  logic             w_errReq;

  assign w_ab     = {i_sens_a, i_sens_b};
  assign w_midSeq = (r_state == S_F1) || (r_state == S_F2) || (r_state == S_F3) ||
                    (r_state == S_R1) || (r_state == S_R2) || (r_state == S_R3);

  // State register. Reset simply returns to IDLE. The sequence in flight is
  // dropped silently, so no pulse is produced.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Timer restarts on every state change and otherwise counts up. It sticks
  // at its maximum so that long stays in IDLE or WAIT_REL never wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_timer <= '0;
    end else if (w_stateNext != r_state) begin
      r_timer <= '0;
    end else if (r_timer != TIMER_MAX) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // Next-state decode of the sampled AB pair. Count requests are raised on the
  // release (00) that completes a passage from F3 or R3. A stalled
  // mid-sequence state is forced to WAIT_REL, so the user has to let go of
  // both sensors before a new passage can begin.
  always_comb begin
    w_stateNext = r_state;
    w_incReq    = 1'b0;
    w_decReq    = 1'b0;
    w_errReq    = 1'b0;
    case (r_state)
      S_IDLE: begin
        case (w_ab)
          2'b10:   w_stateNext = S_F1;
          2'b01:   w_stateNext = S_R1;
          2'b11:   w_stateNext = S_WAIT_REL;
          default: w_stateNext = S_IDLE;
        endcase
      end
      S_F1: begin
        case (w_ab)
          2'b11:   w_stateNext = S_F2;
          2'b00:   w_stateNext = S_IDLE;
          2'b01:   w_stateNext = S_WAIT_REL;
          default: w_stateNext = S_F1;
        endcase
      end
      S_F2: begin
        case (w_ab)
          2'b01:   w_stateNext = S_F3;
          2'b10:   w_stateNext = S_F1;
          2'b00:   w_stateNext = S_WAIT_REL;
          default: w_stateNext = S_F2;
        endcase
      end
      S_F3: begin
        case (w_ab)
          2'b11:   w_stateNext = S_F2;
          2'b10:   w_stateNext = S_WAIT_REL;
          2'b00: begin
            w_stateNext = S_HOLD;
            w_incReq    = 1'b1;
          end
          default: w_stateNext = S_F3;
        endcase
      end
      S_R1: begin
        case (w_ab)
          2'b11:   w_stateNext = S_R2;
          2'b00:   w_stateNext = S_IDLE;
          2'b10:   w_stateNext = S_WAIT_REL;
          default: w_stateNext = S_R1;
        endcase
      end
      S_R2: begin
        case (w_ab)
          2'b10:   w_stateNext = S_R3;
          2'b01:   w_stateNext = S_R1;
          2'b00:   w_stateNext = S_WAIT_REL;
          default: w_stateNext = S_R2;
        endcase
      end
      S_R3: begin
        case (w_ab)
          2'b11:   w_stateNext = S_R2;
          2'b01:   w_stateNext = S_WAIT_REL;
          2'b00: begin
            w_stateNext = S_HOLD;
            w_decReq    = 1'b1;
          end
          default: w_stateNext = S_R3;
        endcase
      end
      S_HOLD: begin
        case (w_ab)
          2'b10:   w_stateNext = S_F1;
          2'b01:   w_stateNext = S_R1;
          2'b11:   w_stateNext = S_WAIT_REL;
          default: w_stateNext = (r_timer == HOLD_LAST) ? S_IDLE : S_HOLD;
        endcase
      end
      S_WAIT_REL: begin
        if (w_ab == 2'b00) begin
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase

    // Timeout only applies when the inputs would otherwise leave us in place.
    if (w_midSeq && (w_stateNext == r_state) && (r_timer == TIMEOUT_LAST)) begin
      w_stateNext = S_WAIT_REL;
      w_errReq    = 1'b1;
    end
  end

  // Count and event pulses are registered. They appear the cycle after the
  // completing sample. Clear wins over a simultaneous request and silences
  // its pulse. The timeout error belongs to the FSM, so clear leaves it alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count    <= '0;
      r_incPulse <= 1'b0;
      r_decPulse <= 1'b0;
      r_rejPulse <= 1'b0;
      r_errPulse <= 1'b0;
    end else begin
      r_incPulse <= 1'b0;
      r_decPulse <= 1'b0;
      r_rejPulse <= 1'b0;
      r_errPulse <= w_errReq;
      if (i_clear) begin
        r_count <= '0;
      end else if (w_incReq) begin
        if (r_count == COUNT_MAX) begin
          r_rejPulse <= 1'b1;
        end else begin
          r_count    <= r_count + COUNT_ONE;
          r_incPulse <= 1'b1;
        end
      end else if (w_decReq) begin
        if (r_count == '0) begin
          r_rejPulse <= 1'b1;
        end else begin
          r_count    <= r_count - COUNT_ONE;
          r_decPulse <= 1'b1;
        end
      end
    end
  end

  assign o_count     = r_count;
  assign o_inc_pulse = r_incPulse;
  assign o_dec_pulse = r_decPulse;
  assign o_rej_pulse = r_rejPulse;
  assign o_err_pulse = r_errPulse;
  assign o_showstat  = (r_state == S_HOLD);
  assign o_busy      = w_midSeq || (r_state == S_WAIT_REL);
  assign o_full      = (r_count == COUNT_MAX);
  assign o_empty     = (r_count == '0);

endmodule

// File: tb/tb_gate_direction_counter.sv
// ---------------------------------------------------------------------------
// tb_gate_direction_counter
//
// Purpose:
//   Self-checking bench for gate_direction_counter. Directed sensor sequences
//   push the event they should produce (kind and resulting count) into an
//   expected queue. A monitor pops an entry every time the DUT raises an event
//   pulse and compares against it. State-like outputs (count, busy, showstat,
//   full, empty) are checked directly at chosen points in the sequence.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_gate_direction_counter;

  localparam int WIDTH       = 8;
  localparam int MAX_COUNT   = 3;
  localparam int TIMEOUT     = 20;
  localparam int HOLD_CYCLES = 50;

  localparam int EV_INC = 1;
  localparam int EV_DEC = 2;
  localparam int EV_REJ = 3;
  localparam int EV_ERR = 4;

  typedef struct {
    int kind;
    int cnt;
  } expEvent_t;

  logic             i_clk;
  logic             i_rst;
  logic             i_sens_a;
  logic             i_sens_b;
  logic             i_clear;
  logic [WIDTH-1:0] o_count;
  logic             o_inc_pulse;
  logic             o_dec_pulse;
  logic             o_rej_pulse;
  logic             o_err_pulse;
  logic             o_showstat;
  logic             o_busy;
  logic             o_full;
  logic             o_empty;

  expEvent_t expQ[$];
  int        assertCount = 0;
  int        failCount   = 0;

  gate_direction_counter #(
    .WIDTH      (WIDTH),
    .MAX_COUNT  (MAX_COUNT),
    .TIMEOUT    (TIMEOUT),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sens_a   (i_sens_a),
    .i_sens_b   (i_sens_b),
    .i_clear    (i_clear),
    .o_count    (o_count),
    .o_inc_pulse(o_inc_pulse),
    .o_dec_pulse(o_dec_pulse),
    .o_rej_pulse(o_rej_pulse),
    .o_err_pulse(o_err_pulse),
    .o_showstat (o_showstat),
    .o_busy     (o_busy),
    .o_full     (o_full),
    .o_empty    (o_empty)
  );

  // 10-unit clock period.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Every comparison goes through here, so the counters stay in one place.
  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Hold the sensor pair for a number of rising edges. Inputs change 1 unit
  // after an edge, and the task returns 1 unit after the last edge.
  task automatic applyStimulus(input logic a, input logic b, input int cycles);
    i_sens_a = a;
    i_sens_b = b;
    repeat (cycles) @(posedge i_clk);
    #1;
  endtask

  task automatic pushExpected(input int kind, input int cnt);
    expEvent_t e;
    e.kind = kind;
    e.cnt  = cnt;
    expQ.push_back(e);
  endtask

  // Forward passage 10,11,01 (3 cycles each) then a single 00 edge. The task
  // returns in the first HOLD cycle.
  task automatic forwardPassage(input int expKind, input int expCnt);
    pushExpected(expKind, expCnt);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 1);
  endtask

  task automatic reversePassage(input int expKind, input int expCnt);
    pushExpected(expKind, expCnt);
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1);
  endtask

  // Monitor: on any event pulse, pop the expected event and compare its kind
  // and the count visible in the same cycle. Only one pulse may be high.
  logic [3:0] monPulses;
  int         monKind;
  expEvent_t  monExp;

  always @(negedge i_clk) begin
    monPulses = {o_inc_pulse, o_dec_pulse, o_rej_pulse, o_err_pulse};
    if (monPulses != 4'b0000) begin
      checkOutput("onePulseOnly", $countones(monPulses), 1);
      monKind = o_inc_pulse ? EV_INC : o_dec_pulse ? EV_DEC : o_rej_pulse ? EV_REJ : EV_ERR;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedPulse", monKind, 0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("pulseKind", monKind, monExp.kind);
        checkOutput("pulseCount", int'(o_count), monExp.cnt);
      end
    end
  end

  // Safety net so the run always ends even if the DUT locks up.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int showCycles;
  int errCycle;
  int errSeen;

  initial begin
    i_rst    = 1'b1;
    i_sens_a = 1'b0;
    i_sens_b = 1'b0;
    i_clear  = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;

    // Reset state
    checkOutput("rstCount", int'(o_count), 0);
    checkOutput("rstEmpty", int'(o_empty), 1);
    checkOutput("rstFull", int'(o_full), 0);
    checkOutput("rstBusy", int'(o_busy), 0);
    checkOutput("rstShowstat", int'(o_showstat), 0);
    checkOutput("rstPulses", int'(o_inc_pulse) + int'(o_dec_pulse) + int'(o_rej_pulse) + int'(o_err_pulse), 0);
    i_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 2);

    // Forward passage from reset, then measure the status window
    forwardPassage(EV_INC, 1);
    checkOutput("fwdCount", int'(o_count), 1);
    checkOutput("fwdEmpty", int'(o_empty), 0);
    showCycles = 0;
    while (o_showstat && showCycles < 200) begin
      showCycles++;
      @(posedge i_clk);
      #1;
    end
    checkOutput("showstatCycles", showCycles, HOLD_CYCLES);
    checkOutput("idleBusyAfterHold", int'(o_busy), 0);

    // Reverse from 2 down to 0, then one more is rejected at empty
    forwardPassage(EV_INC, 2);
    applyStimulus(1'b0, 1'b0, 55);
    reversePassage(EV_DEC, 1);
    checkOutput("revCount", int'(o_count), 1);
    checkOutput("revShowstat", int'(o_showstat), 1);
    applyStimulus(1'b0, 1'b0, 55);
    reversePassage(EV_DEC, 0);
    applyStimulus(1'b0, 1'b0, 55);
    reversePassage(EV_REJ, 0);
    checkOutput("revRejCount", int'(o_count), 0);
    checkOutput("revRejEmpty", int'(o_empty), 1);
    applyStimulus(1'b0, 1'b0, 55);

    // Back-out: A pressed, both, back to A, released. No event is expected.
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("backoutCount", int'(o_count), 0);
    checkOutput("backoutBusy", int'(o_busy), 0);
    checkOutput("backoutShowstat", int'(o_showstat), 0);

    // Illegal jump 10 -> 01 parks in WAIT_REL until both are released
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("illegalBusy", int'(o_busy), 1);
    applyStimulus(1'b0, 1'b1, 5);
    checkOutput("illegalStayBusy", int'(o_busy), 1);
    checkOutput("illegalShowstat", int'(o_showstat), 0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("illegalReleaseBusy", int'(o_busy), 0);
    checkOutput("illegalCount", int'(o_count), 0);

    // Saturation at MAX_COUNT = 3
    forwardPassage(EV_INC, 1);
    applyStimulus(1'b0, 1'b0, 55);
    forwardPassage(EV_INC, 2);
    applyStimulus(1'b0, 1'b0, 55);
    forwardPassage(EV_INC, 3);
    checkOutput("satFull", int'(o_full), 1);
    applyStimulus(1'b0, 1'b0, 55);
    forwardPassage(EV_REJ, 3);
    checkOutput("satCount", int'(o_count), 3);
    checkOutput("satFullStill", int'(o_full), 1);
    applyStimulus(1'b0, 1'b0, 55);

    // Clear on the same edge as a completing passage drops the request
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 3);
    i_clear = 1'b1;
    applyStimulus(1'b0, 1'b0, 1);
    i_clear = 1'b0;
    checkOutput("clearCount", int'(o_count), 0);
    checkOutput("clearEmpty", int'(o_empty), 1);
    checkOutput("clearFull", int'(o_full), 0);
    checkOutput("clearShowstat", int'(o_showstat), 1);
    applyStimulus(1'b0, 1'b0, 55);

    // Timeout: hold 11 in F2; error shows in the 21st cycle after entry
    applyStimulus(1'b1, 1'b0, 3);
    pushExpected(EV_ERR, 0);
    i_sens_a = 1'b1;
    i_sens_b = 1'b1;
    errCycle = 0;
    errSeen  = 0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge i_clk);
      #1;
      if (o_err_pulse) begin
        errSeen++;
        errCycle = k;
      end
    end
    checkOutput("timeoutCycle", errCycle, TIMEOUT + 1);
    checkOutput("timeoutOnce", errSeen, 1);
    checkOutput("timeoutBusy", int'(o_busy), 1);
    checkOutput("timeoutCount", int'(o_count), 0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("timeoutReleaseBusy", int'(o_busy), 0);

    // Reset while in R2 aborts silently and clears the count
    forwardPassage(EV_INC, 1);
    applyStimulus(1'b0, 1'b0, 55);
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 2);
    checkOutput("preRstBusy", int'(o_busy), 1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("midRstCount", int'(o_count), 0);
    checkOutput("midRstBusy", int'(o_busy), 0);
    checkOutput("midRstShowstat", int'(o_showstat), 0);
    checkOutput("midRstPulses", int'(o_inc_pulse) + int'(o_dec_pulse) + int'(o_rej_pulse) + int'(o_err_pulse), 0);
    i_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("postRstBusy", int'(o_busy), 0);
    checkOutput("postRstEmpty", int'(o_empty), 1);

    checkOutput("expectedQueueDrained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/gate_direction_counter.md
Name: gate_direction_counter

Overview:
- Clocked, parametrised successor to the two-button pass-through decoder.
- Decodes the order in which two pre-debounced sensors, A and B, assert and release, and from that detects forward and reverse passages.
- Keeps a saturating occupancy count, and times out abandoned sequences.
- Shows a timed "status" window after each passage.
- Sits between the debouncers and the display and grade logic.

Parameters:
WIDTH, 8, count width in bits
MAX_COUNT, 255, saturation ceiling (must be ≤ 2^WIDTH-1 and ≥ 1)
TIMEOUT, 1000, cycles without an input change in a mid-sequence state before abort
HOLD_CYCLES, 50, cycles the status window is held after a passage

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
sens_a  in  1  sensor A, already debounced and synchronous to clk
sens_b  in  1  sensor B, already debounced and synchronous to clk
clear  in  1  synchronous count clear; does not affect the FSM
count  out  WIDTH  current occupancy
inc_pulse  out  1  one cycle; count was incremented
dec_pulse  out  1  one cycle; count was decremented
rej_pulse  out  1  one cycle; a passage was rejected due to saturation
err_pulse  out  1  one cycle; a sequence was aborted by timeout
showstat  out  1  high while in HOLD
busy  out  1  high in F1–F3, R1–R3 and WAIT_REL
full  out  1  count == MAX_COUNT
empty  out  1  count == 0

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE, count = 0, timer = 0.
  - All pulses 0, showstat 0, busy 0, empty 1, full 0.
  - `rst` aborts any sequence in progress; no pulse is generated.
- Inputs are sampled each rising edge. In the table below, "AB" is the sampled pair: 10 = A only, 01 = B only, 11 = both, 00 = none.
- FSM states: IDLE, F1, F2, F3, R1, R2, R3, HOLD, WAIT_REL. Encoding is free.
  - IDLE: 10→F1, 01→R1, 11→WAIT_REL, 00→stay.
  - F1: 10 stay, 11→F2, 00→IDLE (back-out), 01→WAIT_REL.
  - F2: 11 stay, 01→F3, 10→F1, 00→WAIT_REL.
  - F3: 01 stay, 11→F2, 10→WAIT_REL, 00→HOLD with increment request.
  - R1: 01 stay, 11→R2, 00→IDLE, 10→WAIT_REL.
  - R2: 11 stay, 10→R3, 01→R1, 00→WAIT_REL.
  - R3: 10 stay, 11→R2, 01→WAIT_REL, 00→HOLD with decrement request.
  - HOLD: 00 stays until timer == HOLD_CYCLES-1, then →IDLE; 10→F1, 01→R1, 11→WAIT_REL (window cut short).
  - WAIT_REL: →IDLE on 00; otherwise stay.
- Timer:
  - Clears on every state change and counts up otherwise.
  - Width is `$clog2(max(TIMEOUT,HOLD_CYCLES)+1)`.
  - In F1–F3 and R1–R3, when the timer reaches TIMEOUT-1 with no transition, the FSM goes to WAIT_REL and err_pulse fires the next cycle.
- Counter:
  - An increment or decrement request is applied on the same edge that enters HOLD.
  - count, inc_pulse and dec_pulse are registered: they become visible the cycle after the 00 sample, with the pulse high for exactly one cycle.
  - Increment at MAX_COUNT: count unchanged, rej_pulse instead of inc_pulse.
  - Decrement at 0: count unchanged, rej_pulse instead of dec_pulse.
  - No wrap-around ever.
  - clear: count ← 0 on the next edge.
  - clear has priority over a simultaneous request. That request is dropped, and neither inc_pulse/dec_pulse nor rej_pulse fires.
- Derived outputs:
  - full, empty and showstat are derived from the registered count and state, with no extra latency.
  - showstat is high during every HOLD cycle.
- Ordering: at most one count event per passage, and at most one of inc_pulse, dec_pulse, rej_pulse and err_pulse is high in any cycle.

Test Plan:
- Forward: AB = 10,11,01,00 (each held 3 cycles) from reset → count = 1, inc_pulse for 1 cycle; showstat high 50 cycles, then IDLE, busy low.
- Reverse from count = 2: AB = 01,11,10,00 → count = 1, dec_pulse once. Reverse from count = 0 → rej_pulse, count stays 0.
- Back-out: 10,11,10,00 → no pulses, count unchanged, IDLE.
- Illegal jump: 10 then 01 → WAIT_REL, busy high; it stays while 01 and goes to IDLE on 00; no count change.
- Saturation and clear: MAX_COUNT = 3, four forward passages → count = 3, full = 1, 4th gives rej_pulse. clear asserted on the same edge as a completing forward passage → count = 0, no inc_pulse, no rej_pulse.
- Timeout and reset: TIMEOUT = 20, hold 11 in F2 for 25 cycles → err_pulse once at the 21st cycle, WAIT_REL. rst asserted while in R2 → IDLE next cycle, count = 0, no pulses.
